// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and pattern ids for the LED pattern sequencer.
package led_pattern_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  localparam logic [2:0] PAT_SHIFT_R   = 3'd0;
  localparam logic [2:0] PAT_SHIFT_L   = 3'd1;
  localparam logic [2:0] PAT_FILL_R    = 3'd2;
  localparam logic [2:0] PAT_FILL_L    = 3'd3;
  localparam logic [2:0] PAT_SHIFT_OUT = 3'd4;
  localparam logic [2:0] PAT_SHIFT_IN  = 3'd5;
  localparam logic [2:0] PAT_FILL_OUT  = 3'd6;
  localparam logic [2:0] PAT_FILL_IN   = 3'd7;

  localparam int FRAMES_LONG  = 9;
  localparam int FRAMES_SHORT = 5;

  // Patterns 0..3 walk all eight LEDs, 4..7 walk the four symmetric pairs.
  function automatic logic [3:0] last_frame(input logic [2:0] pat);
    return (pat < PAT_SHIFT_OUT) ? 4'(FRAMES_LONG - 1) : 4'(FRAMES_SHORT - 1);
  endfunction

  function automatic logic [2:0] next_pat(input logic [2:0] pat);
    return pat + 3'd1;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Control and LED-bank signals of the pattern sequencer.
interface led_pattern_sequencer_if;
  logic       run;
  logic       auto_en;
  logic       next;
  logic       load;
  logic [2:0] sel;
  logic [7:0] led8;
  logic [2:0] pattern_id;
  logic       pattern_done;

  modport master (
    output run, auto_en, next, load, sel,
    input  led8, pattern_id, pattern_done
  );

  modport slave (
    input  run, auto_en, next, load, sel,
    output led8, pattern_id, pattern_done
  );
endinterface

// File: rtl/led_pattern_sequencer_frame_rom.sv
// Combinational frame table: (pattern, frame) -> LED word plus last-frame flag.
module led_pattern_sequencer_frame_rom
  import led_pattern_sequencer_pkg::*;
(
  input  logic [2:0] pat,
  input  logic [3:0] frame,
  output logic [7:0] led,
  output logic       last
);

  function automatic logic [7:0] short_frame(input logic [1:0] kind, input logic [1:0] f);
    logic [7:0] v;
    case ({kind, f})
      4'b00_00: v = 8'h18;
      4'b00_01: v = 8'h24;
      4'b00_10: v = 8'h42;
      4'b00_11: v = 8'h81;
      4'b01_00: v = 8'h81;
      4'b01_01: v = 8'h42;
      4'b01_10: v = 8'h24;
      4'b01_11: v = 8'h18;
      4'b10_00: v = 8'h18;
      4'b10_01: v = 8'h3C;
      4'b10_10: v = 8'h7E;
      4'b10_11: v = 8'hFF;
      4'b11_00: v = 8'h81;
      4'b11_01: v = 8'hC3;
      4'b11_10: v = 8'hE7;
      default:  v = 8'hFF;
    endcase
    return v;
  endfunction

  // Frames past the lit ones (the trailing blank) fall through to 8'h00.
  always_comb begin
    led  = 8'h00;
    last = (frame == last_frame(pat));
    if (!frame[3]) begin
      case (pat)
        PAT_SHIFT_R: led = 8'h80 >> frame[2:0];
        PAT_SHIFT_L: led = 8'h01 << frame[2:0];
        PAT_FILL_R:  led = 8'hFF << (3'd7 - frame[2:0]);
        PAT_FILL_L:  led = 8'hFF >> (3'd7 - frame[2:0]);
        default: begin
          if (frame[3:2] == 2'b00) led = short_frame(pat[1:0], frame[1:0]);
        end
      endcase
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Eight-LED pattern sequencer: step prescaler, frame/repeat counters, pattern select and auto-advance.
// Outputs are registered; led8 always reflects the registered (pattern, frame) pair.
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int DIV     = 50_000_000,
  parameter int REPEATS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  led_pattern_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(DIV);
  localparam int REP_W = (REPEATS > 1) ? $clog2(REPEATS) : 1;

  state_t           state_q, state_d;
  logic [7:0]       led_q, led_d;
  logic [2:0]       id_q, id_d;
  logic [3:0]       frame_q, frame_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             last_q;
  logic             tick;
  logic [7:0]       rom_led;
  logic             rom_last;

  // The ROM looks up the next (pattern, frame) so led8 and last register together.
  led_pattern_sequencer_frame_rom u_rom (
    .pat   (id_d),
    .frame (frame_d),
    .led   (rom_led),
    .last  (rom_last)
  );

  assign tick = (state_q == ST_PLAY) && bus.run && (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    frame_d = frame_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (state_q == ST_IDLE && bus.run) state_d = ST_PLAY;

    if (bus.load) begin
      id_d    = bus.sel;
      frame_d = '0;
      rep_d   = '0;
      cnt_d   = '0;
    end else if (bus.next) begin
      id_d    = next_pat(id_q);
      frame_d = '0;
      rep_d   = '0;
      cnt_d   = '0;
    end else if (state_q == ST_PLAY && bus.run) begin
      if (tick) begin
        cnt_d = '0;
        if (last_q) begin
          frame_d = '0;
          if (rep_q == REP_W'(REPEATS - 1)) begin
            rep_d  = '0;
            done_d = 1'b1;
            if (bus.auto_en) id_d = next_pat(id_q);
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end else begin
          frame_d = frame_q + 4'd1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    led_d = (state_d == ST_PLAY) ? rom_led : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      led_q   <= 8'h00;
      id_q    <= '0;
      frame_q <= '0;
      rep_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      id_q    <= id_d;
      frame_q <= frame_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      last_q  <= rom_last;
    end
  end

  assign bus.led8         = led_q;
  assign bus.pattern_id   = id_q;
  assign bus.pattern_done = done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scenario tasks plus a randomized run against a table-driven reference model.
module tb_led_pattern_sequencer;

  localparam int DIV     = 4;
  localparam int REPEATS = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_pattern_sequencer_if bus ();

  led_pattern_sequencer #(.DIV(DIV), .REPEATS(REPEATS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] tbl [8][9];
  int         len [8];

  bit         m_play;
  int         m_id, m_frame, m_rep, m_cnt;
  logic [7:0] m_led;
  bit         m_done;

  initial begin
    tbl = '{'{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00},
            '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00},
            '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00},
            '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00},
            '{8'h18, 8'h24, 8'h42, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
            '{8'h81, 8'h42, 8'h24, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
            '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
            '{8'h81, 8'hC3, 8'hE7, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    len = '{9, 9, 9, 9, 5, 5, 5, 5};
  end

  // Drive one clock of inputs, then advance the model by the rules for that edge.
  task automatic cycle(input bit rst, input bit run, input bit auto, input bit nxt,
                       input bit ld, input int sel);
    bit was_play;
    reset       = rst;
    bus.run     = run;
    bus.auto_en = auto;
    bus.next    = nxt;
    bus.load    = ld;
    bus.sel     = 3'(sel);
    @(posedge clk);
    was_play = m_play;
    if (rst) begin
      m_play = 0; m_id = 0; m_frame = 0; m_rep = 0; m_cnt = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (ld) begin
        m_id = sel % 8; m_frame = 0; m_rep = 0; m_cnt = 0;
      end else if (nxt) begin
        m_id = (m_id + 1) % 8; m_frame = 0; m_rep = 0; m_cnt = 0;
      end else if (was_play && run) begin
        m_cnt++;
        if (m_cnt == DIV) begin
          m_cnt = 0;
          m_frame++;
          if (m_frame == len[m_id]) begin
            m_frame = 0;
            m_rep++;
            if (m_rep == REPEATS) begin
              m_rep = 0;
              m_done = 1;
              if (auto) m_id = (m_id + 1) % 8;
            end
          end
        end
      end
      if (run) m_play = 1;
    end
    m_led = m_play ? tbl[m_id][m_frame] : 8'h00;
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 1, 6);
    vectors++;
    if (bus.led8 !== 8'h00 || bus.pattern_id !== 3'd0 || bus.pattern_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: led8=%h id=%0d done=%b, want 00/0/0",
               bus.led8, bus.pattern_id, bus.pattern_done);
    end
    cycle(0, 0, 1, 1, 0, 0);
    vectors++;
    if (bus.led8 !== 8'h00 || bus.pattern_id !== 3'd1) begin
      miscompares++;
      $display("FAIL idle_next: led8=%h id=%0d, want 00/1", bus.led8, bus.pattern_id);
    end
  endtask

  task automatic test_shift_r_auto();
    logic [7:0] exp_r [9];
    int dones = 0;
    exp_r = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    vectors++;
    if (bus.led8 !== 8'h80) begin
      miscompares++;
      $display("FAIL entry_frame: led8=%h want 80", bus.led8);
    end
    for (int i = 1; i < 72; i++) begin
      cycle(0, 1, 1, 0, 0, 0);
      if (bus.pattern_done === 1'b1) dones++;
      vectors++;
      if (bus.led8 !== exp_r[(i / 4) % 9] || bus.pattern_id !== 3'd0) begin
        miscompares++;
        $display("FAIL shift_r_step%0d: led8=%h id=%0d, want %h/0",
                 i, bus.led8, bus.pattern_id, exp_r[(i / 4) % 9]);
      end
    end
    cycle(0, 1, 1, 0, 0, 0);
    vectors++;
    if (bus.pattern_done !== 1'b1 || bus.pattern_id !== 3'd1 || bus.led8 !== 8'h01 || dones != 0) begin
      miscompares++;
      $display("FAIL shift_r_end: done=%b id=%0d led8=%h early=%0d, want 1/1/01/0",
               bus.pattern_done, bus.pattern_id, bus.led8, dones);
    end
  endtask

  task automatic test_full_auto();
    int dones = 0;
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 448; i++) begin
      cycle(0, 1, 1, 0, 0, 0);
      vectors++;
      if (bus.led8 !== m_led || bus.pattern_id !== 3'(m_id) || bus.pattern_done !== m_done) begin
        miscompares++;
        $display("FAIL full_auto_c%0d: led8=%h id=%0d done=%b, want %h/%0d/%b",
                 i, bus.led8, bus.pattern_id, bus.pattern_done, m_led, m_id, m_done);
      end
      if (bus.pattern_done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 8 || bus.pattern_id !== 3'd0 || bus.led8 !== 8'h80) begin
      miscompares++;
      $display("FAIL full_auto_wrap: dones=%0d id=%0d led8=%h, want 8/0/80",
               dones, bus.pattern_id, bus.led8);
    end
  endtask

  task automatic test_pause();
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 1, 6);
    for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, 0, 0, 0);
      vectors++;
      if (bus.led8 !== 8'h3C || bus.pattern_id !== 3'd6) begin
        miscompares++;
        $display("FAIL pause_hold%0d: led8=%h id=%0d, want 3C/6", i, bus.led8, bus.pattern_id);
      end
    end
    cycle(0, 1, 1, 0, 0, 0);
    vectors++;
    if (bus.led8 !== 8'h3C) begin
      miscompares++;
      $display("FAIL resume_early: led8=%h want 3C", bus.led8);
    end
    cycle(0, 1, 1, 0, 0, 0);
    vectors++;
    if (bus.led8 !== 8'h7E) begin
      miscompares++;
      $display("FAIL resume_step: led8=%h want 7E", bus.led8);
    end
  endtask

  task automatic test_priority();
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 1, 5);
    vectors++;
    if (bus.pattern_id !== 3'd5 || bus.led8 !== 8'h81 || bus.pattern_done !== 1'b0) begin
      miscompares++;
      $display("FAIL load_priority: id=%0d led8=%h done=%b, want 5/81/0",
               bus.pattern_id, bus.led8, bus.pattern_done);
    end
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 0);
    vectors++;
    if (bus.led8 !== 8'h81) begin
      miscompares++;
      $display("FAIL load_prescaler_clear: led8=%h want 81", bus.led8);
    end
    cycle(0, 1, 1, 0, 0, 0);
    vectors++;
    if (bus.led8 !== 8'h42) begin
      miscompares++;
      $display("FAIL load_first_step: led8=%h want 42", bus.led8);
    end
  endtask

  task automatic test_no_auto();
    logic [7:0] exp4 [5];
    int dones = 0;
    exp4 = '{8'h18, 8'h24, 8'h42, 8'h81, 8'h00};
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 1, 4);
    for (int i = 1; i <= 80; i++) begin
      cycle(0, 1, 0, 0, 0, 0);
      if (bus.pattern_done === 1'b1) dones++;
      vectors++;
      if (bus.led8 !== exp4[(i / 4) % 5] || bus.pattern_id !== 3'd4 ||
          bus.pattern_done !== ((i % 40) == 0)) begin
        miscompares++;
        $display("FAIL loop4_c%0d: led8=%h id=%0d done=%b, want %h/4/%b", i, bus.led8,
                 bus.pattern_id, bus.pattern_done, exp4[(i / 4) % 5], (i % 40) == 0);
      end
    end
    vectors++;
    if (dones != 2) begin
      miscompares++;
      $display("FAIL loop4_dones: got %0d want 2", dones);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 1, 2);
    for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0, 0, 0);
    vectors++;
    if (bus.led8 !== 8'hF0) begin
      miscompares++;
      $display("FAIL mid_setup: led8=%h want F0", bus.led8);
    end
    cycle(1, 1, 1, 0, 0, 0);
    vectors++;
    if (bus.led8 !== 8'h00 || bus.pattern_id !== 3'd0 || bus.pattern_done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: led8=%h id=%0d done=%b, want 00/0/0",
               bus.led8, bus.pattern_id, bus.pattern_done);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0);
    vectors++;
    if (bus.led8 !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_idle: led8=%h want 00", bus.led8);
    end
    cycle(0, 1, 1, 0, 0, 0);
    vectors++;
    if (bus.led8 !== 8'h80) begin
      miscompares++;
      $display("FAIL mid_restart: led8=%h want 80", bus.led8);
    end
  endtask

  task automatic test_random();
    bit auto = 1;
    cycle(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) auto = ~auto;
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, auto,
            $urandom_range(0, 59) == 0, $urandom_range(0, 79) == 0,
            int'($urandom_range(0, 7)));
      vectors++;
      if (bus.led8 !== m_led || bus.pattern_id !== 3'(m_id) || bus.pattern_done !== m_done) begin
        miscompares++;
        $display("FAIL random_c%0d: led8=%h id=%0d done=%b, want %h/%0d/%b",
                 i, bus.led8, bus.pattern_id, bus.pattern_done, m_led, m_id, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift_r_auto();
    test_full_auto();
    test_pause();
    test_priority();
    test_no_auto();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
